can_frame_decoder: RTL

CAN_FRAME_DECODER -- requirements
Module: can_frame_decoder

---
 rtl/can_frame_decoder_if.sv | 32 +++
 rtl/can_frame_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_decoder_if.sv
// rtl/can_frame_decoder_if.sv - bit input, FIFO head and status signals of can_frame_decoder
interface can_frame_decoder_if #(
  parameter int MAX_BYTES = 8
);
  logic                   bitEn;
  logic                   canRX;
  logic                   outReady;
  logic                   outValid;
  logic [28:0]            outId;
  logic                   outIde;
  logic                   outRtr;
  logic [3:0]             outDlc;
  logic [8*MAX_BYTES-1:0] outData;
  logic [14:0]            outCrc;
  logic                   stuffError;
  logic                   formError;
  logic                   crcError;
  logic                   overflow;
  logic                   busy;

  modport master (
    input  bitEn, canRX, outReady,
    output outValid, outId, outIde, outRtr, outDlc, outData, outCrc,
    output stuffError, formError, crcError, overflow, busy
  );

  modport slave (
    output bitEn, canRX, outReady,
    input  outValid, outId, outIde, outRtr, outDlc, outData, outCrc,
    input  stuffError, formError, crcError, overflow, busy
  );
endinterface

// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - CAN frame receiver with destuffing, CRC-15 check and frame FIFO; CAN_EXT_ID_EN enables extended IDs
module can_frame_decoder #(
  parameter int MAX_BYTES = 8,
  parameter int DEPTH     = 2
) (
  input  logic samplePoint,
  input  logic reset,
  can_frame_decoder_if.master bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  typedef struct packed {
    logic [28:0]            id;
    logic                   ide;
    logic                   rtr;
    logic [3:0]             dlc;
    logic [8*MAX_BYTES-1:0] data;
    logic [14:0]            crc;
  } frame_t;

  state_t                 state_q, state_d;
  logic [3:0]             rec_cnt_q, rec_cnt_d;
  logic                   prev_q, prev_d;
  logic [2:0]             run_q, run_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [3:0]             nbytes_q, nbytes_d;
  logic [28:0]            id_q, id_d;
  logic                   ide_q, ide_d, rtr_q, rtr_d;
  logic [3:0]             dlc_q, dlc_d;
  logic [6:0]             byte_q, byte_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [14:0]            crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic                   stuff_err, form_err, crc_err, push_req, stuff_zone;

  frame_t                 mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic                   full, pop, push_ok;
  frame_t                 head;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  // Bit-level decode: destuffing, field sequencing, CRC accumulation and error detection
  always_comb begin
    state_d = state_q;   rec_cnt_d = rec_cnt_q; prev_d = prev_q;  run_d = run_q;
    cnt_d = cnt_q;       nbytes_d = nbytes_q;   id_d = id_q;      ide_d = ide_q;
    rtr_d = rtr_q;       dlc_d = dlc_q;         byte_d = byte_q;  data_d = data_q;
    crc_d = crc_q;       crc_rx_d = crc_rx_q;
    stuff_err = 1'b0;    form_err = 1'b0;       crc_err = 1'b0;   push_req = 1'b0;
    stuff_zone = (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL});
    if (bus.bitEn && !reset) begin
      if (stuff_zone && run_q == 3'd5) begin
        // Stuff slot: the bit is discarded but must differ from the run
        if (bus.canRX == prev_q) begin
          stuff_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
        end else begin
          prev_d = bus.canRX; run_d = 3'd1;
        end
      end else begin
        if (stuff_zone) begin
          run_d  = (bus.canRX == prev_q) ? run_q + 3'd1 : 3'd1;
          prev_d = bus.canRX;
        end
        case (state_q)
          S_WAIT_IDLE: begin
            if (!bus.canRX) rec_cnt_d = '0;
            else if (rec_cnt_q == 4'd10) begin state_d = S_IDLE; rec_cnt_d = '0; end
            else rec_cnt_d = rec_cnt_q + 4'd1;
          end
          S_IDLE: begin
            if (!bus.canRX) begin
              state_d = S_ARB; prev_d = 1'b0; run_d = 3'd1; crc_d = '0; cnt_d = '0;
              nbytes_d = '0; id_d = '0; ide_d = 1'b0; rtr_d = 1'b0; dlc_d = '0;
              byte_d = '0; data_d = '0; crc_rx_d = '0;
            end
          end
          S_ARB: begin
            crc_d = crc_step(crc_q, bus.canRX);
            cnt_d = cnt_q + 6'd1;
            if (cnt_q <= 6'd10 || (cnt_q >= 6'd13 && cnt_q <= 6'd30)) begin
`ifdef CAN_EXT_ID_EN
              id_d = {id_q[27:0], bus.canRX};
`else
              id_d = {18'd0, id_q[9:0], bus.canRX};
`endif
            end
            if (cnt_q == 6'd11) rtr_d = bus.canRX;
            if (cnt_q == 6'd12) begin
              if (!bus.canRX) begin
                state_d = S_CTRL; cnt_d = '0;
              end else begin
`ifdef CAN_EXT_ID_EN
                ide_d = 1'b1;
`else
                form_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
`endif
              end
            end
            if (cnt_q == 6'd31) begin
              rtr_d = bus.canRX; state_d = S_CTRL; cnt_d = '0;
            end
          end
          S_CTRL: begin
            // Reserved bits shift through and fall off the top of the DLC register
            crc_d = crc_step(crc_q, bus.canRX);
            dlc_d = {dlc_q[2:0], bus.canRX};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == (ide_q ? 6'd5 : 6'd4)) begin
              if (rtr_q) nbytes_d = '0;
              else if (dlc_d > 4'd8) nbytes_d = 4'd8;
              else nbytes_d = dlc_d;
              cnt_d   = '0;
              state_d = (nbytes_d == 4'd0) ? S_CRC : S_DATA;
            end
          end
          S_DATA: begin
            crc_d  = crc_step(crc_q, bus.canRX);
            byte_d = {byte_q[5:0], bus.canRX};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q[2:0] == 3'd7) begin
              for (int b = 0; b < MAX_BYTES; b++) begin
                if (int'(cnt_q[5:3]) == b) data_d[b*8 +: 8] = {byte_q, bus.canRX};
              end
            end
            if ({1'b0, cnt_q} == {nbytes_q, 3'b000} - 7'd1) begin
              state_d = S_CRC; cnt_d = '0;
            end
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], bus.canRX};
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd14) begin state_d = S_CRC_DEL; cnt_d = '0; end
          end
          S_CRC_DEL: begin
            if (crc_rx_q != crc_q) begin
              crc_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
            end else if (!bus.canRX) begin
              form_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
            end else state_d = S_ACK;
          end
          S_ACK: state_d = S_ACK_DEL;
          S_ACK_DEL: begin
            if (!bus.canRX) begin
              form_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
            end else begin
              state_d = S_EOF; cnt_d = '0;
            end
          end
          S_EOF: begin
            if (!bus.canRX) begin
              form_err = 1'b1; state_d = S_WAIT_IDLE; rec_cnt_d = '0;
            end else if (cnt_q == 6'd6) begin
              push_req = 1'b1; state_d = S_IDLE;
            end else cnt_d = cnt_q + 6'd1;
          end
          default: begin
            state_d = S_WAIT_IDLE; rec_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // Decoder state register
  always_ff @(posedge samplePoint) begin
    if (reset) begin
      state_q <= S_WAIT_IDLE; rec_cnt_q <= '0; prev_q <= 1'b1; run_q <= '0; cnt_q <= '0;
      nbytes_q <= '0; id_q <= '0; ide_q <= 1'b0; rtr_q <= 1'b0; dlc_q <= '0;
      byte_q <= '0; data_q <= '0; crc_q <= '0; crc_rx_q <= '0;
    end else begin
      state_q <= state_d; rec_cnt_q <= rec_cnt_d; prev_q <= prev_d; run_q <= run_d; cnt_q <= cnt_d;
      nbytes_q <= nbytes_d; id_q <= id_d; ide_q <= ide_d; rtr_q <= rtr_d; dlc_q <= dlc_d;
      byte_q <= byte_d; data_q <= data_d; crc_q <= crc_d; crc_rx_q <= crc_rx_d;
    end
  end

  assign full    = (count_q == FULL_CNT);
  assign pop     = bus.outValid && bus.outReady;
  assign push_ok = push_req && (!full || pop);

  // Frame FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
  always_ff @(posedge samplePoint) begin
    if (reset) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {id_q, ide_q, rtr_q, dlc_q, data_q, crc_rx_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop) count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.outValid   = (count_q != '0);
  assign bus.outId      = bus.outValid ? head.id   : '0;
  assign bus.outIde     = bus.outValid ? head.ide  : 1'b0;
  assign bus.outRtr     = bus.outValid ? head.rtr  : 1'b0;
  assign bus.outDlc     = bus.outValid ? head.dlc  : '0;
  assign bus.outData    = bus.outValid ? head.data : '0;
  assign bus.outCrc     = bus.outValid ? head.crc  : '0;
  assign bus.stuffError = stuff_err;
  assign bus.formError  = form_err;
  assign bus.crcError   = crc_err;
  assign bus.overflow   = push_req && full && !pop;
  assign bus.busy       = (state_q != S_IDLE);
endmodule
